// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: size codes, FSM states
// and the latched request bundle.
package ram_arb_pkg;

  localparam int ARB_AW = 12;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ARB_AW+1:0] addr;
    logic [31:0]       wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational; error flag covers misalignment and size 2'b11.
module mem_lane_align
  import ram_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_alo,
  input  logic        i_sgn,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_din,
  output logic        o_err,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_b = i_rword[{i_alo, 3'b000} +: 8];
  assign w_h = i_rword[{i_alo[1], 4'b0000} +: 16];

  always_comb begin
    o_be    = '0;
    o_din   = '0;
    o_err   = 1'b0;
    o_rdata = '0;
    unique case (1'b1)
      (i_size == SZ_BYTE): begin
        o_be    = 4'b0001 << i_alo;
        o_din   = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sgn & w_b[7]}}, w_b};
      end
      (i_size == SZ_HALF): begin
        o_be    = i_alo[1] ? 4'b1100 : 4'b0011;
        o_din   = {2{i_wdata[15:0]}};
        o_err   = i_alo[0];
        o_rdata = {{16{i_sgn & w_h[15]}}, w_h};
      end
      (i_size == SZ_WORD): begin
        o_be    = 4'b1111;
        o_din   = i_wdata;
        o_err   = |i_alo;
        o_rdata = i_rword;
      end
      default: o_err = 1'b1;
    endcase
    if (o_err) o_rdata = '0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the
// byte-enabled synchronous-read data RAM.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_signed,
  input  logic [AW+1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_signed,
  input  logic [AW+1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_read_signed,
  output logic [1:0]    ram_read_size,
  input  logic [DW-1:0] ram_dout
);

  arb_state_t r_state, w_next;
  arb_req_t   r_req, w_sel;
  logic       r_owner;
  logic       r_last;

  logic        w_open, w_go, w_pick1;
  logic        w_issue, w_resp, w_wr;
  logic [3:0]  w_be;
  logic [31:0] w_din, w_ld, w_rd;
  logic        w_err;

  // r_last = 1 means m1 won the previous grant
  assign w_open  = (r_state != ISSUE) && !rst;
  assign w_go    = w_open && (m0_req || m1_req);
  assign w_pick1 = (m0_req && m1_req) ? !r_last : m1_req;
  assign m0_gnt  = w_go && !w_pick1;
  assign m1_gnt  = w_go && w_pick1;

  assign w_sel = w_pick1 ?
    '{m1_we, m1_size, m1_signed, m1_addr, m1_wdata} :
    '{m0_we, m0_size, m0_signed, m0_addr, m0_wdata};

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == ISSUE): w_next = RESP;
      default:            w_next = w_go ? ISSUE : IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_req   <= w_sel;
        r_owner <= w_pick1;
        r_last  <= w_pick1;
      end
    end
  end

  mem_lane_align u_align (
    .i_size  (r_req.size),
    .i_alo   (r_req.addr[1:0]),
    .i_sgn   (r_req.sgn),
    .i_wdata (r_req.wdata),
    .i_rword (ram_dout),
    .o_be    (w_be),
    .o_din   (w_din),
    .o_err   (w_err),
    .o_rdata (w_ld)
  );

  assign w_issue = (r_state == ISSUE);
  assign w_resp  = (r_state == RESP);
  assign w_wr    = w_issue && r_req.we && !w_err;

  assign ram_we   = w_wr;
  assign ram_be   = w_wr ? w_be : '0;
  assign ram_addr = w_issue ? r_req.addr[AW+1:2] : '0;
  assign ram_din  = (w_issue && r_req.we) ? w_din : '0;

  assign ram_read_signed = 1'b0;
  assign ram_read_size   = SZ_WORD;

  assign w_rd = r_req.we ? '0 : w_ld;

  assign m0_rvalid = w_resp && !r_owner;
  assign m1_rvalid = w_resp && r_owner;
  assign m0_rdata  = m0_rvalid ? w_rd : '0;
  assign m1_rdata  = m1_rvalid ? w_rd : '0;
  assign m0_err    = m0_rvalid && w_err;
  assign m1_err    = m1_rvalid && w_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-enabled
// synchronous-read RAM model behind it.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m0_signed = 0;
  logic [1:0]  m0_size = 0;
  logic [13:0] m0_addr = 0;
  logic [31:0] m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_signed = 0;
  logic [1:0]  m1_size = 0;
  logic [13:0] m1_addr = 0;
  logic [31:0] m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we, ram_read_signed;
  logic [3:0]  ram_be;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [1:0]  ram_read_size;

  logic [31:0] mem [0:4095];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size),
    .m0_signed(m0_signed), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size),
    .m1_signed(m1_signed), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_read_signed(ram_read_signed),
    .ram_read_size(ram_read_size), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [1:0] sz, input logic sg,
                       input logic [13:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = rq; m0_we = we; m0_size = sz;
      m0_signed = sg; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = rq; m1_we = we; m1_size = sz;
      m1_signed = sg; m1_addr = a; m1_wdata = wd;
    end
  endtask

  // starts at posedge+1 in IDLE or RESP, ends at posedge+1 in RESP
  task automatic do_acc(input string tag, input int p,
                        input logic we, input logic [1:0] sz,
                        input logic sg, input logic [13:0] a,
                        input logic [31:0] wd, input logic [3:0] ebe,
                        input logic [31:0] edin, input logic eerr,
                        input logic [31:0] erd);
    logic ewe;
    ewe = we && !eerr;
    drive(p, 1'b1, we, sz, sg, a, wd);
    #1;
    check({tag, ".gnt0"}, m0_gnt, p == 0);
    check({tag, ".gnt1"}, m1_gnt, p == 1);
    @(posedge clk); #1;
    drive(p, 1'b0, ~we, ~sz, ~sg, ~a, ~wd);
    check({tag, ".nognt"}, {m0_gnt, m1_gnt}, 0);
    check({tag, ".we"}, ram_we, ewe);
    check({tag, ".be"}, ram_be, ebe);
    check({tag, ".addr"}, ram_addr, a[13:2]);
    if (ewe) check({tag, ".din"}, ram_din, edin);
    @(posedge clk); #1;
    check({tag, ".rv"}, p == 0 ? m0_rvalid : m1_rvalid, 1);
    check({tag, ".rvx"}, p == 0 ? m1_rvalid : m0_rvalid, 0);
    check({tag, ".err"}, p == 0 ? m0_err : m1_err, eerr);
    check({tag, ".rd"}, p == 0 ? m0_rdata : m1_rdata, erd);
    check({tag, ".rdx"}, p == 0 ? m1_rdata : m0_rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt", {m0_gnt, m1_gnt}, 0);
    check("rst.rv", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
    check("rst.rd", m0_rdata | m1_rdata, 0);
    check("rst.ram", {ram_we, ram_be, ram_addr}, 0);
    check("rst.din", ram_din, 0);
    check("rst.tie", {ram_read_signed, ram_read_size}, 3'b010);
    rst = 1'b0;

    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 14'h100, 32'hAAAA0000);
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 14'h200, 32'h55550000);
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        int g;
        g = (k / 2) % 2;
        check($sformatf("rr.gnt%0d", k), {m0_gnt, m1_gnt},
              g == 0 ? 2'b10 : 2'b01);
        check($sformatf("rr.rv%0d", k), {m0_rvalid, m1_rvalid},
              k == 0 ? 2'b00 : (g == 1 ? 2'b10 : 2'b01));
      end else begin
        check($sformatf("rr.idle%0d", k), {m0_gnt, m1_gnt}, 0);
        check($sformatf("rr.we%0d", k), ram_we, 1);
      end
      if (k == 11) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("rr.last", {m0_rvalid, m1_rvalid}, 2'b01);
    check("rr.mem0", mem[12'h040], 32'hAAAA0000);

    do_acc("ldm1", 1, 0, 2'b10, 0, 14'h200, 0, 4'b0000, 0, 0,
           32'h55550000);
    do_acc("sw", 0, 1, 2'b10, 0, 14'h010, 32'hDEADBEEF, 4'b1111,
           32'hDEADBEEF, 0, 0);
    do_acc("lw", 0, 0, 2'b10, 0, 14'h010, 0, 4'b0000, 0, 0,
           32'hDEADBEEF);
    do_acc("sb", 0, 1, 2'b00, 0, 14'h013, 32'h00000080, 4'b1000,
           32'h80808080, 0, 0);
    do_acc("lbs", 0, 0, 2'b00, 1, 14'h013, 0, 4'b0000, 0, 0,
           32'hFFFFFF80);
    do_acc("lbu", 0, 0, 2'b00, 0, 14'h013, 0, 4'b0000, 0, 0,
           32'h00000080);
    do_acc("sh", 0, 1, 2'b01, 0, 14'h022, 32'h00008001, 4'b1100,
           32'h80018001, 0, 0);
    do_acc("lhs", 0, 0, 2'b01, 1, 14'h022, 0, 4'b0000, 0, 0,
           32'hFFFF8001);
    do_acc("sw4", 1, 1, 2'b10, 0, 14'h004, 32'h11111111, 4'b1111,
           32'h11111111, 0, 0);
    do_acc("swmis", 0, 1, 2'b10, 0, 14'h005, 32'h12345678, 4'b0000,
           0, 1, 0);
    do_acc("lw4", 0, 0, 2'b10, 0, 14'h004, 0, 4'b0000, 0, 0,
           32'h11111111);
    do_acc("lhmis", 1, 0, 2'b01, 1, 14'h023, 0, 4'b0000, 0, 1, 0);
    do_acc("szill", 0, 0, 2'b11, 0, 14'h010, 0, 4'b0000, 0, 1, 0);

    drive(0, 1'b1, 1'b1, 2'b10, 0, 14'h010, 32'h99999999);
    #1;
    check("rs.gnt", m0_gnt, 1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    check("rs.we", ram_we, 1);
    rst = 1'b1;
    #1;
    check("rs.wedrop", {ram_we, ram_be}, 0);
    @(posedge clk); #1;
    check("rs.norv1", {m0_rvalid, m1_rvalid}, 0);
    @(posedge clk); #1;
    check("rs.norv2", {m0_rvalid, m1_rvalid}, 0);
    rst = 1'b0;
    do_acc("rs.lw", 0, 0, 2'b10, 0, 14'h010, 0, 4'b0000, 0, 0,
           32'h80ADBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
